// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_scoreboard_pkg                                              |
// | Shared pipeline constants and encodings for the hazard scoreboard. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package hazard_scoreboard_pkg;

    localparam int NREG     = 32;
    localparam int REG_W    = 5;
    localparam int LOAD_LAT = 2;
    localparam int CNT_W    = 3;

    typedef enum logic [1:0] {
        CLASS_ALU  = 2'b00,
        CLASS_LOAD = 2'b01,
        CLASS_LONG = 2'b10,
        CLASS_RSVD = 2'b11
    } id_class_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_RAW  = 2'b01,
        CAUSE_WAW  = 2'b10,
        CAUSE_BUSY = 2'b11
    } stall_cause_e;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_src_check.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | scb_src_check                                                      |
// | RAW hazard test for one source operand, with writeback bypass.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module scb_src_check #(
    parameter int NREG  = 32,
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] i_idx,
    input  logic             i_used,
    input  logic [NREG-1:0]  i_cnt_busy,
    input  logic [NREG-1:0]  i_pend,
    input  logic             i_wb_valid,
    input  logic [REG_W-1:0] i_wb_rd,
    output logic             o_hazard
);

    logic w_tracked;
    logic w_wb_hit;

    assign w_tracked = i_used && (i_idx != '0);
    // A writeback landing this cycle feeds the consumer directly.
    assign w_wb_hit  = i_wb_valid && (i_wb_rd == i_idx);
    assign o_hazard  = w_tracked && (i_cnt_busy[i_idx] || (i_pend[i_idx] && !w_wb_hit));

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_scoreboard                                                  |
// | Decode-stage producer tracker: stalls issue on RAW/WAW/busy.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module hazard_scoreboard #(
    parameter int NREG     = hazard_scoreboard_pkg::NREG,
    parameter int REG_W    = hazard_scoreboard_pkg::REG_W,
    parameter int LOAD_LAT = hazard_scoreboard_pkg::LOAD_LAT,
    parameter int CNT_W    = hazard_scoreboard_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rd_wr,
    input  logic [1:0]       id_class,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    output logic             issue_ready,
    output logic [1:0]       stall_cause,
    output logic             long_busy,
    output logic             protocol_err
);

    import hazard_scoreboard_pkg::*;

    localparam logic [CNT_W-1:0] c_load_cnt = CNT_W'(LOAD_LAT - 1);

    logic [CNT_W-1:0] r_cnt [NREG];
    logic [NREG-1:0]  r_pend;
    logic             r_long_busy;
    logic             r_protocol_err;

    logic [NREG-1:0]  w_cnt_busy;
    logic             w_raw1;
    logic             w_raw2;
    logic             w_waw;
    logic             w_busy;
    logic             w_issue;
    logic             w_rd_write;
    logic             w_wb_bad;
    id_class_e        w_class;
    stall_cause_e     w_cause;

    generate
        for (genvar g = 0; g < NREG; g++) begin : g_cnt_busy
            assign w_cnt_busy[g] = (r_cnt[g] != '0);
        end
    endgenerate

    scb_src_check #(.NREG(NREG), .REG_W(REG_W)) u_rs1_check (
        .i_idx      (id_rs1),
        .i_used     (id_rs1_used),
        .i_cnt_busy (w_cnt_busy),
        .i_pend     (r_pend),
        .i_wb_valid (wb_valid),
        .i_wb_rd    (wb_rd),
        .o_hazard   (w_raw1)
    );

    scb_src_check #(.NREG(NREG), .REG_W(REG_W)) u_rs2_check (
        .i_idx      (id_rs2),
        .i_used     (id_rs2_used),
        .i_cnt_busy (w_cnt_busy),
        .i_pend     (r_pend),
        .i_wb_valid (wb_valid),
        .i_wb_rd    (wb_rd),
        .o_hazard   (w_raw2)
    );

    assign w_class    = id_class_e'(id_class);
    assign w_waw      = id_rd_wr && (id_rd != '0) && r_pend[id_rd] &&
                        !(wb_valid && (wb_rd == id_rd));
    assign w_busy     = (w_class == CLASS_LONG) && r_long_busy && !wb_valid;
    assign w_issue    = id_valid && issue_ready && !flush;
    assign w_rd_write = w_issue && id_rd_wr && (id_rd != '0);
    assign w_wb_bad   = (wb_rd == '0) || !r_pend[wb_rd];

    always_comb begin
        w_cause = CAUSE_NONE;
        if (!rst && id_valid) begin
            if (w_raw1 || w_raw2) begin
                w_cause = CAUSE_RAW;
            end else if (w_waw) begin
                w_cause = CAUSE_WAW;
            end else if (w_busy) begin
                w_cause = CAUSE_BUSY;
            end
        end
    end

    assign issue_ready  = !rst && (w_cause == CAUSE_NONE);
    assign stall_cause  = w_cause;
    assign long_busy    = r_long_busy;
    assign protocol_err = r_protocol_err;

    // Later assignments win: issue overrides decrement, and a LONG issue overrides writeback clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_pend         <= '0;
            r_long_busy    <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (flush) begin
                    r_cnt[i] <= '0;
                end else if (w_cnt_busy[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end

            if (wb_valid) begin
                if (w_wb_bad) begin
                    r_protocol_err <= 1'b1;
                end else begin
                    r_pend[wb_rd] <= 1'b0;
                    r_long_busy   <= 1'b0;
                end
            end

            if (w_rd_write) begin
                case (w_class)
                    CLASS_LOAD: r_cnt[id_rd] <= c_load_cnt;
                    CLASS_LONG: begin
                        r_cnt[id_rd]  <= '0;
                        r_pend[id_rd] <= 1'b1;
                        r_long_busy   <= 1'b1;
                    end
                    default:    r_cnt[id_rd] <= '0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
